// File: rtl/bus_mem.sv
// bus_mem: single-port word memory with a pipelined read path.
// Bad accesses pulse err; good accesses feed saturating counters.
module bus_mem #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 1024,
  parameter int BASE   = 0,
  parameter int RD_LAT = 1,
  parameter logic [DATA_W-1:0] IDLE_DATA = 32'hDEDEAFAF,
  parameter int CNT_W  = 16
) (
  input  logic              clkIn,
  input  logic              rst,
  input  logic              cs,
  input  logic              we,
  input  logic [ADDR_W-1:0] ADDR,
  input  logic [DATA_W-1:0] DATA_BUS_WRITE,
  output logic [DATA_W-1:0] DATA_BUS_READ,
  output logic              rvalid,
  output logic              err,
  output logic [CNT_W-1:0]  rd_cnt,
  output logic [CNT_W-1:0]  wr_cnt
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LAST  = RD_LAT - 1;

  localparam logic [ADDR_W:0] P_LO =
    (ADDR_W+1)'(BASE);
  localparam logic [ADDR_W:0] P_HI =
    (ADDR_W+1)'(BASE + 4*DEPTH);

  if (RD_LAT < 1 || RD_LAT > 4) begin : g_bad_lat
    $fatal(1, "bus_mem: RD_LAT must be 1..4");
  end
  if (DEPTH < 1 || (DEPTH & (DEPTH-1)) != 0) begin : g_bad_depth
    $fatal(1, "bus_mem: DEPTH must be a power of 2");
  end

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_dat [RD_LAT];
  logic [RD_LAT-1:0] r_vld;
  logic [RD_LAT-1:0] r_bad;
  logic              r_werr;
  logic [CNT_W-1:0]  r_rd_cnt;
  logic [CNT_W-1:0]  r_wr_cnt;

  logic [ADDR_W:0]   w_addr;
  logic [ADDR_W:0]   w_off;
  logic [IDX_W-1:0]  w_idx;
  logic              w_good;
  logic              w_rd;
  logic              w_wr;

  // The extra top bit keeps the range compare safe near the address ceiling.
  assign w_addr = {1'b0, ADDR};
  assign w_off  = w_addr - P_LO;
  assign w_idx  = IDX_W'(w_off >> 2);
  assign w_good = (w_addr >= P_LO) &&
                  (w_addr <  P_HI) &&
                  (ADDR[1:0] == 2'b00);
  assign w_rd   = cs & ~we;
  assign w_wr   = cs &  we;

  // Storage write; gated by rst so requests during reset do nothing.
  always_ff @(posedge clkIn) begin
    if (rst && w_wr && w_good)
      r_mem[w_idx] <= DATA_BUS_WRITE;
  end

  // Read data is captured at acceptance so later writes cannot leak in.
  always_ff @(posedge clkIn) begin
    r_dat[0] <= w_good ? r_mem[w_idx] : IDLE_DATA;
    for (int i = 1; i < RD_LAT; i++)
      r_dat[i] <= r_dat[i-1];
  end

  // Read-pipeline valid/bad tags; reset drops any in-flight reads.
  always_ff @(posedge clkIn or negedge rst) begin
    if (!rst) begin
      r_vld <= '0;
      r_bad <= '0;
    end else begin
      r_vld[0] <= w_rd;
      r_bad[0] <= w_rd & ~w_good;
      for (int i = 1; i < RD_LAT; i++) begin
        r_vld[i] <= r_vld[i-1];
        r_bad[i] <= r_bad[i-1];
      end
    end
  end

  // Bad-write flag shows up in the cycle after the offending edge.
  always_ff @(posedge clkIn or negedge rst) begin
    if (!rst)
      r_werr <= 1'b0;
    else
      r_werr <= w_wr & ~w_good;
  end

  // Saturating counters of good accesses.
  always_ff @(posedge clkIn or negedge rst) begin
    if (!rst) begin
      r_rd_cnt <= '0;
      r_wr_cnt <= '0;
    end else begin
      if (w_rd && w_good && r_rd_cnt != '1)
        r_rd_cnt <= r_rd_cnt + 1'b1;
      if (w_wr && w_good && r_wr_cnt != '1)
        r_wr_cnt <= r_wr_cnt + 1'b1;
    end
  end

  // A bad read carries IDLE_DATA in its data slot already.
  assign rvalid        = r_vld[LAST];
  assign DATA_BUS_READ = rvalid ? r_dat[LAST] : IDLE_DATA;
  assign err           = r_werr | (rvalid & r_bad[LAST]);
  assign rd_cnt        = r_rd_cnt;
  assign wr_cnt        = r_wr_cnt;

endmodule
